// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file definitions for the writeback path.
// Supplies the register-file geometry, the default write-requester count,
// the write-enable levels and the zero word used by the write arbiter and
// its sub-blocks.
package regfile_wr_arbiter_pkg;

  localparam int unsigned RegNumLog2 = 5;
  localparam int unsigned RegNum     = 1 << RegNumLog2;
  localparam int unsigned RegAddrBus = RegNumLog2;
  localparam int unsigned RegBus     = 32;

  // Default number of writeback sources: ALU, load unit, mul/div.
  localparam int unsigned WrReqNum   = 3;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_wr_arbiter_rr.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   req       request vector, one bit per requester
//   gnt       one-hot grant, combinational from req and the pointer
//   gnt_any   some requester is granted this cycle
// The search starts at the pointer and wraps; after a grant the pointer moves
// just past the winner, so every requester is served within N cycles.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_any
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + k) % N;
      if (!gnt_any && req[PW'(idx)]) begin
        gnt[PW'(idx)] = 1'b1;
        gnt_idx       = PW'(idx);
        gnt_any       = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Shares the single register-file write port between NREQ writeback sources
// through a round-robin arbiter and a one-cycle registered write stage, and
// tracks which registers have an in-flight producer so decode can stall.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/addr/data        per-requester write (addr/data packed by index)
//   req_ready                  one-hot grant; transfer on valid & ready
//   we, waddr, wdata           register-file write port (registered)
//   sb_set, sb_addr            decode marks sb_addr as pending
//   rd_addr1..3, busy1..3      scoreboard lookups (two sources, one dest)
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = WrReqNum,
  parameter int unsigned AW   = RegNumLog2,
  parameter int unsigned DW   = RegBus
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic             we,
  output logic [AW-1:0]    waddr,
  output logic [DW-1:0]    wdata,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  input  logic [AW-1:0]    rd_addr3,
  output logic             busy1,
  output logic             busy2,
  output logic             busy3
);

  localparam int unsigned NumRegs = 1 << AW;

  logic [NREQ-1:0]    gnt;
  logic               gnt_any;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic               do_write;
  logic [NumRegs-1:0] busy_q, busy_d;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  // One-hot AND-OR select of the winning requester's payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr[i*AW +: AW];
        sel_data = sel_data | req_data[i*DW +: DW];
      end
    end
  end

  // x0 writes are accepted and retired without touching the register file.
  assign do_write = gnt_any && (sel_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we    <= WriteDisable;
      waddr <= '0;
      wdata <= '0;
    end else if (do_write) begin
      we    <= WriteEnable;
      waddr <= sel_addr;
      wdata <= sel_data;
    end else begin
      we    <= WriteDisable;
    end
  end

  // Clear first so a same-edge set of the same register wins: that set
  // belongs to a newer producer still in flight.
  always_comb begin
    busy_d = busy_q;
    if (do_write) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (sb_set && (sb_addr != '0)) begin
      busy_d[sb_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookups see registered state only; the write stage bypass covers the
  // cycle in which a bit clears.
  assign busy1 = busy_q[rd_addr1];
  assign busy2 = busy_q[rd_addr2];
  assign busy3 = busy_q[rd_addr3];

endmodule
